// File: rtl/aes_pkg.sv
// Shared AES key-expansion definitions.
//   - state_t   : expander FSM states
//   - SBOX_FLAT : forward S-box, entry 0 in the most significant byte
//   - sbox()    : single-byte S-box lookup
//   - xtime()   : multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1
//   - aes_nk()  : key length in 32-bit words
//   - aes_nr()  : number of cipher rounds
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  // Entry a sits at bits [2047-8a -: 8]; 2047-8a is exactly {~a, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_FLAT[{~a, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int aes_nk(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int aes_nr(input int key_bits);
    return aes_nk(key_bits) + 6;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
//   word_in  : input word
//   word_out : byte-wise S-box substitution of word_in
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES key-expansion engine (AES-128/192/256).
// Loads a cipher key, derives one schedule word per clock and keeps the
// whole schedule for random access through a combinational round-key port.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : expand key_in (accepted only in IDLE)
//   key_in     : cipher key, most significant word is w[0]
//   busy       : expansion in progress
//   done       : one-cycle pulse when the schedule is complete
//   valid      : schedule readable, held until next accepted start or reset
//   rk_idx     : round-key index 0..NR
//   rk_out     : {w[4r], w[4r+1], w[4r+2], w[4r+3]}, zero if not readable
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                valid,
  input  logic [3:0]          rk_idx,
  output logic [127:0]        rk_out
);

  localparam int NK = aes_nk(KEY_BITS);
  localparam int NR = aes_nr(KEY_BITS);
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  state_t         state;
  state_t         state_next;
  logic [31:0]    w_mem [NW];
  logic [IW-1:0]  idx;     // index of the next word to write
  logic [2:0]     phase;   // idx mod NK, kept as a wrapping counter
  logic [7:0]     rcon;

  logic [31:0]    prev_word;
  logic [31:0]    old_word;
  logic [31:0]    sub_in;
  logic [31:0]    sub_out;
  logic [31:0]    temp;
  logic [31:0]    new_word;
  logic [3:0]     rk_sel;

  // ---------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (idx == IW'(NW - 1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register in the
    // block samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      phase <= '0;
      rcon  <= 8'h01;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= IW'(NK);
            phase <= '0;
            rcon  <= 8'h01;
            valid <= 1'b0;
          end
        end
        EXPAND: begin
          idx   <= idx + IW'(1);
          phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rcon <= xtime(rcon);
        end
        DONE: valid <= 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Word datapath
  // ---------------------------------------------------------------------
  assign prev_word = w_mem[idx - IW'(1)];
  assign old_word  = w_mem[idx - IW'(NK)];

  // RotWord only on the first word of each key-length group.
  assign sub_in = (phase == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_sub_word u_sub_word (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    temp = prev_word;
    if (phase == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h0};
    end else if (NK == 8 && phase == 3'd4) begin
      temp = sub_out;
    end
  end

  assign new_word = old_word ^ temp;

  // NOTE: the schedule array has no reset; valid gates every read, so its
  // contents never matter until a full expansion has rewritten them.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int k = 0; k < NK; k++) begin
        w_mem[k] <= key_in[KEY_BITS-1-32*k -: 32];
      end
    end else if (state == EXPAND) begin
      w_mem[idx] <= new_word;
    end
  end

  // ---------------------------------------------------------------------
  // Round-key read port
  // ---------------------------------------------------------------------
  // Out-of-range indices are clamped before addressing so the array is
  // never read past its end; the result is then forced to zero anyway.
  assign rk_sel = (rk_idx > 4'(NR)) ? 4'd0 : rk_idx;

  always_comb begin
    rk_out = '0;
    if (valid && rk_idx <= 4'(NR)) begin
      rk_out = {w_mem[{rk_sel, 2'b00}], w_mem[{rk_sel, 2'b01}],
                w_mem[{rk_sel, 2'b10}], w_mem[{rk_sel, 2'b11}]};
    end
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Sequential, parametrised AES key-expansion engine for AES-128, AES-192 and AES-256.
- Loads a cipher key and computes one 32-bit schedule word per clock.
- Stores the full schedule and serves any round key through a combinational read port.
- Replaces per-round combinational key-schedule logic, which needs an externally computed SubWord/Rcon term. This block computes SubWord, RotWord and Rcon internally.

Parameters:
- KEY_BITS, 128, cipher key width. Legal values are 128, 192 and 256; any other value is an elaboration error.
- Derived, not overridable: NK = KEY_BITS/32 (4/6/8), NR = NK+6 (10/12/14), NW = 4*(NR+1) (44/52/60).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request expansion of key_in; sampled only in IDLE.
- key_in  in  KEY_BITS  cipher key. key_in[KEY_BITS-1 -: 32] is w[0].
- busy  out  1  high while expansion is in progress.
- done  out  1  one-cycle pulse when the schedule is complete.
- valid  out  1  schedule readable; held until the next accepted start or reset.
- rk_idx  in  4  round-key index, 0..NR.
- rk_out  out  128  {w[4*rk_idx], w[4*rk_idx+1], w[4*rk_idx+2], w[4*rk_idx+3]}, most significant word first.

Behaviour:
- Reset (async assert, sync deassert internally handled by the system): state=IDLE, busy=0, done=0, valid=0, word counter=0, rcon=8'h01. The word array is not cleared.
- rk_out is combinational from rk_idx. It is 128'h0 when valid=0 or rk_idx>NR.
- States and transitions:
  - IDLE: when start=1, on that edge write w[0..NK-1] from key_in, set i=NK, phase counter=0, rcon=8'h01, valid=0, busy=1, and go to EXPAND. When start=0, stay in IDLE.
  - EXPAND: each edge writes w[i] and increments i. When the word written is w[NW-1], go to DONE.
  - DONE: done=1 and busy=0 for this one cycle; valid set on the exit edge. Then go to IDLE.
- Word rule, with temp taken from w[i-1]:
  - i mod NK == 0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}. After use, rcon <= xtime(rcon), giving 01,02,04,08,10,20,40,80,1b,36.
  - NK==8 and i mod 8 == 4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
  - w[i] = w[i-NK] ^ temp.
- i mod NK comes from a phase counter that wraps at NK-1. No divider is used.
- RotWord(a,b,c,d) = (b,c,d,a), with byte a = bits [31:24].
- Latency: the first EXPAND write is on the edge after start is accepted. done is high in the cycle after NW-NK EXPAND edges (40/46/52 cycles after the start edge).
- busy=1 from the start edge until DONE is entered.
- start while busy or in DONE is ignored, not queued.
- Reset mid-expansion aborts immediately. valid stays 0 and a new start is required.
- start in IDLE while valid=1 clears valid on that edge. The old schedule is not readable during re-expansion.
- key_in is sampled only on the start edge. Later changes have no effect.
- rk_idx may change every cycle. rk_out reflects it in the same cycle.

Decomposition:
- Package aes_pkg holds:
  - the 256-entry S-box constant;
  - function xtime(byte);
  - functions aes_nk(key_bits) and aes_nr(key_bits);
  - the state enum typedef {IDLE, EXPAND, DONE}.
- Sub-module aes_sub_word: combinational, 32-bit in and 32-bit out, four S-box lookups. One instance only.
- The word array, FSM, phase counter and rcon register live in aes_key_expander.

Test Plan:
1. KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
   - done exactly 40 cycles after the start edge;
   - rk_idx=1 gives a0fafe1788542cb123a339392a6c7605;
   - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6;
   - rk_idx=0 returns the key.
2. KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f:
   - rk_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5;
   - rk_idx=11 gives 0.
3. KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
   - done after 46 cycles;
   - rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
4. KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
   - done after 52 cycles;
   - rk_idx=14 gives fe4890d1e6188d0b046df344706c631e.
   - This exercises the i mod 8 == 4 SubWord path.
5. Control and reset:
   - Re-pulse start and change key_in at cycle 10 of expansion: no effect, results as in test 1.
   - Drop rst_n at cycle 20: busy=0, valid=0, rk_out=0 immediately.
   - New start completes correctly.
6. After test 1 completes (valid=1), start with key 000102…0f:
   - valid drops on the start edge;
   - rk_out=0 during expansion;
   - test-2 values appear after done.
